zeta_table_writer: RTL and testbench
====================================

ZETA_TABLE_WRITER -- requirements
Module: zeta_table_writer

Interface
REQ-001 SHALL have parameter NTT_STAGE_CNT, default 8: N = 1<<(NTT_STAGE_CNT-1) zeta entries, indices k = 1..N-1 written.
REQ-002 SHALL have parameter DATA_WIDTH, default 12: width of a zeta value.
REQ-003 SHALL have parameter Q, default 3329: modulus, Q < 2^DATA_WIDTH.
REQ-004 SHALL have parameter ROOT, default 17: primitive root, ROOT < Q.
REQ-005 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  one-cycle request to (re)generate the table.
REQ-008 SHALL have port busy  output  1  high whenever the FSM is not IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse after the last write handshake.
REQ-010 SHALL have port wr_valid  output  1  write request to the per-stage zeta RAM.
REQ-011 SHALL have port wr_ready  input  1  RAM accepts write when high with wr_valid.
REQ-012 SHALL have port wr_stage  output  $clog2(NTT_STAGE_CNT)  target stage RAM.
REQ-013 SHALL have port wr_addr  output  NTT_STAGE_CNT-1  local address inside the stage RAM.
REQ-014 SHALL have port wr_data  output  DATA_WIDTH  zeta value.

Function
REQ-015 SHALL iterate j = 1..N-1, with cur = ROOT^j mod Q.
REQ-016 SHALL map j to k = bit-reverse of j over NTT_STAGE_CNT-1 bits; wr_stage = floor(log2 k); wr_addr = k - 2^wr_stage; wr_data = cur.
REQ-017 SHALL implement states IDLE, MUL, RED, WRITE, DONE.
REQ-018 IDLE: on start, load cur=1, j=0, go to MUL; otherwise stay.
REQ-019 MUL: prod <= cur*ROOT (2*DATA_WIDTH bits, no truncation); go to RED.
REQ-020 RED: cur <= prod mod Q (full reduction, result in [0,Q-1]); j <= j+1; go to WRITE.
REQ-021 WRITE: wr_valid=1 with stage/addr/data from current j and cur; hold all four stable until wr_ready=1.
REQ-022 On WRITE handshake: if j==N-1 go to DONE, else go to MUL.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE.
REQ-024 Latency: with wr_ready tied high, first wr_valid 3 cycles after the start-sampling edge; successive writes 3 cycles apart; done 1 cycle after last handshake.
REQ-025 SHALL write exactly N-1 entries per run, each (stage, addr) exactly once; k=0 never written.
REQ-026 start while busy SHALL be ignored, including in DONE.
REQ-027 wr_ready low SHALL stall indefinitely in WRITE with no state or output change; wr_ready outside WRITE has no effect.
REQ-028 wr_valid SHALL be 0 in every state except WRITE.
REQ-029 wr_stage/wr_addr/wr_data outside WRITE are don't-care but SHALL be X-free after reset.

Reset
REQ-030 rst high at a rising edge SHALL force IDLE, busy=0, done=0, wr_valid=0, cur=1, j=0, prod=0, and zero wr_stage/wr_addr/wr_data; rst has priority over start.
REQ-031 rst mid-run SHALL abort with no further writes; a later start SHALL regenerate from j=1.

Verification
REQ-032 Defaults, wr_ready=1, start pulse at cycle 0 -> cycle 3: stage 6, addr 0, data 17; cycle 6: stage 5, addr 0, data 289; cycle 9: stage 6, addr 32, data 1584.
REQ-033 Same run -> j=64 writes stage 0, addr 0, data 1729; 127 writes total; done at cycle 382 only; busy low at cycle 383.
REQ-034 Stall test: wr_ready=0 for 10 cycles during the first WRITE -> wr_valid and stage 6/addr 0/data 17 held all 10 cycles; exactly one write accepted.
REQ-035 Reset test: rst pulsed at cycle 50 -> wr_valid=0 and busy=0 next cycle, no writes until a new start; next run reproduces REQ-032 values.
REQ-036 start re-pulsed at cycles 5 and 382 -> ignored; write sequence and done timing identical to REQ-033.
REQ-037 Scoreboard: captured table compared against a reference model computing ROOT^brv(k) mod Q for all k=1..127 -> zero mismatches, no duplicate addresses.

Source files
------------

// File: rtl/zeta_table_writer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : zeta_table_writer_if
//  Description : Write port from the zeta generator into the per-stage RAMs.
//  Revision    : 1.0
// ============================================================================
interface zeta_table_writer_if #(
    parameter int NTT_STAGE_CNT = 8,
    parameter int DATA_WIDTH    = 12
);
    localparam int c_STAGE_W = $clog2(NTT_STAGE_CNT);
    localparam int c_ADDR_W  = NTT_STAGE_CNT - 1;

    logic                  wr_valid;
    logic                  wr_ready;
    logic [c_STAGE_W-1:0]  wr_stage;
    logic [c_ADDR_W-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_stage,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_stage,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface
`default_nettype wire

// File: rtl/zeta_table_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : zeta_table_writer
//  Description : Generates ROOT^j mod Q for j=1..N-1 and writes each value to
//                the stage RAM selected by the bit-reversed index of j.
//  Revision    : 1.0
// ============================================================================
module zeta_table_writer #(
    parameter int NTT_STAGE_CNT = 8,
    parameter int DATA_WIDTH    = 12,
    parameter int Q             = 3329,
    parameter int ROOT          = 17
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        start,
    output logic             busy,
    output logic             done,
    zeta_table_writer_if.master wr
);
    localparam int c_STAGE_W = $clog2(NTT_STAGE_CNT);
    localparam int c_ADDR_W  = NTT_STAGE_CNT - 1;
    localparam int c_PROD_W  = 2 * DATA_WIDTH;
    localparam logic [c_ADDR_W-1:0] c_J_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MUL   = 3'd1,
        S_RED   = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_cur;
    logic [c_ADDR_W-1:0]   r_j;
    logic [c_PROD_W-1:0]   r_prod;

    logic [c_ADDR_W-1:0]   w_k;
    logic [c_STAGE_W-1:0]  w_stage;
    logic [c_ADDR_W-1:0]   w_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_MUL;
            S_MUL:   w_next = S_RED;
            S_RED:   w_next = S_WRITE;
            S_WRITE: begin
                if (wr.wr_ready) begin
                    w_next = (r_j == c_J_LAST) ? S_DONE : S_MUL;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur  <= DATA_WIDTH'(1);
            r_j    <= '0;
            r_prod <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cur <= DATA_WIDTH'(1);
                        r_j   <= '0;
                    end
                end
                S_MUL: r_prod <= c_PROD_W'(r_cur) * c_PROD_W'(ROOT);
                S_RED: begin
                    r_cur <= DATA_WIDTH'(r_prod % c_PROD_W'(Q));
                    r_j   <= r_j + c_ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // k = bitrev(j); stage is the index of k's leading one, addr is k without it
    always_comb begin
        w_k     = '0;
        w_stage = '0;
        for (int i = 0; i < c_ADDR_W; i++) begin
            w_k[i] = r_j[c_ADDR_W-1-i];
        end
        for (int i = 0; i < c_ADDR_W; i++) begin
            if (w_k[i]) w_stage = c_STAGE_W'(i);
        end
        w_addr = w_k & ~(c_ADDR_W'(1) << w_stage);
    end

    assign wr.wr_valid = (r_state == S_WRITE);
    assign wr.wr_stage = wr.wr_valid ? w_stage : '0;
    assign wr.wr_addr  = wr.wr_valid ? w_addr  : '0;
    assign wr.wr_data  = wr.wr_valid ? r_cur   : '0;

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
endmodule
`default_nettype wire

// File: tb/tb_zeta_table_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_zeta_table_writer
//  Description : Scoreboard bench for the zeta table writer.
//  Revision    : 1.0
// ============================================================================
module tb_zeta_table_writer;
    localparam int NSC = 8;
    localparam int DW  = 12;
    localparam int QM  = 3329;
    localparam int RT  = 17;
    localparam int AW  = NSC - 1;
    localparam int NW  = (1 << AW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic done;

    zeta_table_writer_if #(.NTT_STAGE_CNT(NSC), .DATA_WIDTH(DW)) wr_if ();

    zeta_table_writer #(
        .NTT_STAGE_CNT(NSC),
        .DATA_WIDTH   (DW),
        .Q            (QM),
        .ROOT         (RT)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .busy (busy),
        .done (done),
        .wr   (wr_if)
    );

    always #5 clk = ~clk;

    int pe = 0;
    always @(posedge clk) pe <= pe + 1;

    typedef struct {
        int stage;
        int addr;
        int data;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   t0 = 0;
    int   tests = 0;
    int   fails = 0;
    int   wr_cnt = 0;
    int   done_cnt = 0;
    int   done_cyc = -1;
    bit   seen[256];
    int   cap[256];

    // Monitor: every accepted write is popped from the scoreboard and compared
    always @(negedge clk) begin
        exp_t e;
        int   k;
        int   rel;
        rel = pe - t0;
        if (wr_if.wr_valid === 1'b1 && wr_if.wr_ready === 1'b1) begin
            k = ((1 << wr_if.wr_stage) + int'(wr_if.wr_addr)) & 255;
            wr_cnt++;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write cyc=%0d: got stage=%0d addr=%0d data=%0d, expected no write",
                         rel, wr_if.wr_stage, wr_if.wr_addr, wr_if.wr_data);
            end else begin
                e = sb.pop_front();
                if (int'(wr_if.wr_stage) != e.stage || int'(wr_if.wr_addr) != e.addr ||
                    int'(wr_if.wr_data) != e.data || rel != e.cyc) begin
                    fails++;
                    $display("FAIL write: got stage=%0d addr=%0d data=%0d cyc=%0d, expected stage=%0d addr=%0d data=%0d cyc=%0d",
                             wr_if.wr_stage, wr_if.wr_addr, wr_if.wr_data, rel,
                             e.stage, e.addr, e.data, e.cyc);
                end
            end
            tests++;
            if (seen[k]) begin
                fails++;
                $display("FAIL duplicate_addr: got second write to k=%0d, expected one", k);
            end
            seen[k] = 1'b1;
            cap[k]  = int'(wr_if.wr_data);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = rel;
        end
    end

    task automatic chk(input string name, input int got, input int expv);
        tests++;
        if (got != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    task automatic tick_to(input int c);
        while ((pe - t0) < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: ROOT^j mod Q written at k = bitrev7(j), one write per 3 cycles
    task automatic push_run(input int extra);
        int cur;
        cur = 1;
        for (int j = 1; j <= NW; j++) begin
            int   k;
            int   s;
            exp_t e;
            cur = (cur * RT) % QM;
            k = 0;
            for (int b = 0; b < AW; b++) k |= ((j >> b) & 1) << (AW - 1 - b);
            s = 0;
            for (int b = 0; b < AW; b++) if (((k >> b) & 1) == 1) s = b;
            e.stage = s;
            e.addr  = k - (1 << s);
            e.data  = cur;
            e.cyc   = 3 * j + extra;
            sb.push_back(e);
        end
    endtask

    task automatic start_run();
        @(posedge clk);
        #1;
        for (int i = 0; i < 256; i++) begin
            seen[i] = 1'b0;
            cap[i]  = -1;
        end
        wr_cnt   = 0;
        done_cnt = 0;
        done_cyc = -1;
        start    = 1'b1;
        t0       = pe;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic finish_run(input int extra, input bit directed);
        tick_to(383 + extra);
        chk("busy_low_after_done", int'(busy), 0);
        chk("done_pulse_count", done_cnt, 1);
        chk("done_cycle", done_cyc, 382 + extra);
        chk("write_count", wr_cnt, NW);
        chk("scoreboard_empty", sb.size(), 0);
        if (directed) begin
            chk("k64_data", cap[64], 17);
            chk("k32_data", cap[32], 289);
            chk("k96_data", cap[96], 1584);
            chk("k1_data", cap[1], 1729);
        end
    endtask

    initial begin
        wr_if.wr_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_wr_valid", int'(wr_if.wr_valid), 0);
        chk("rst_bus", int'({wr_if.wr_stage, wr_if.wr_addr, wr_if.wr_data}), 0);
        rst = 1'b0;

        // Nominal run
        push_run(0);
        start_run();
        chk("busy_in_run", int'(busy), 1);
        tick_to(2);
        chk("no_valid_before_cycle3", int'(wr_if.wr_valid), 0);
        finish_run(0, 1'b1);

        // Back-pressure on the first write
        push_run(10);
        start_run();
        tick_to(3);
        wr_if.wr_ready = 1'b0;
        for (int c = 3; c < 13; c++) begin
            tick_to(c);
            chk("stall_valid", int'(wr_if.wr_valid), 1);
            chk("stall_word", int'({wr_if.wr_stage, wr_if.wr_addr, wr_if.wr_data}),
                (6 << (AW + DW)) | 17);
        end
        tick_to(13);
        wr_if.wr_ready = 1'b1;
        finish_run(10, 1'b1);

        // Abort mid-run, then regenerate
        push_run(0);
        start_run();
        tick_to(50);
        rst = 1'b1;
        tick_to(51);
        rst = 1'b0;
        chk("abort_wr_valid", int'(wr_if.wr_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("writes_before_abort", wr_cnt, 16);
        sb.delete();
        tick_to(80);
        chk("no_writes_after_abort", wr_cnt, 16);
        chk("no_done_after_abort", done_cnt, 0);
        push_run(0);
        start_run();
        finish_run(0, 1'b1);

        // start while busy, including in DONE
        push_run(0);
        start_run();
        tick_to(5);
        start = 1'b1;
        tick_to(6);
        start = 1'b0;
        tick_to(382);
        start = 1'b1;
        tick_to(383);
        start = 1'b0;
        finish_run(0, 1'b0);
        tick_to(386);
        chk("ignored_start_in_done", int'(busy), 0);
        chk("no_extra_writes", wr_cnt, NW);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
